rmii_phy_emu: RTL and testbench

RMII PHY-side endpoint for the 10M and 100M RMII link. It lets an FPGA present itself directly as the "PHY" to an RMII MAC, which serves MAC-to-MAC links and self-test of our RMII MAC path.

- Receive side: takes the MAC's transmit dibits, strips preamble/SFD and emits a byte stream.
- Transmit side: takes a byte stream with valid/ready, then generates preamble, SFD, data dibits, CRS_DV and the inter-frame gap toward the MAC.

---
 rtl/rmii_phy_emu.sv | 341 ++++++++++++++++++++++++++++++++++
 tb/tb_rmii_phy_emu.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmii_phy_emu.sv
// -----------------------------------------------------------------------------
// rmii_phy_emu
// PHY-side RMII endpoint. Lets the FPGA act as the "PHY" toward an RMII MAC.
//   Receive side : MAC TX_EN/TXD dibits -> preamble/SFD stripped -> byte stream.
//   Transmit side: byte stream (valid/ready/last) -> preamble, SFD, data dibits,
//                  CRS_DV and inter-frame gap toward the MAC.
// Ports
//   rmii_ref_clk        50 MHz reference clock (only clock)
//   rst                 synchronous reset, active high
//   mode_speed          0: 10M (one action per 10 cycles), 1: 100M (every cycle)
//   mac_rmii_txen/txd   dibits from the MAC
//   mac_rmii_crsdv/rxer/rxd  registered dibit outputs toward the MAC
//   tx_valid/tx_ready/tx_data/tx_last  byte input; tx_underflow abort pulse
//   rx_valid/rx_data    received byte pulse; rx_end/rx_err end-of-frame pulse
// -----------------------------------------------------------------------------
module rmii_phy_emu #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_BYTES      = 12
) (
    input  logic       rmii_ref_clk,
    input  logic       rst,
    input  logic       mode_speed,
    input  logic       mac_rmii_txen,
    input  logic [1:0] mac_rmii_txd,
    output logic       mac_rmii_crsdv,
    output logic       mac_rmii_rxer,
    output logic [1:0] mac_rmii_rxd,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_underflow,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_end,
    output logic       rx_err
);

    // Preamble: PREAMBLE_BYTES*4 dibits of 01 plus the three leading 01 dibits of the SFD.
    localparam logic [6:0] PRE_PERIODS = 7'(PREAMBLE_BYTES * 4 + 3);
    localparam logic [6:0] IFG_PERIODS = 7'(IFG_BYTES * 4);

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_PRE   = 3'd1,
        TX_SFD   = 3'd2,
        TX_DATA  = 3'd3,
        TX_UNDER = 3'd4,
        TX_IFG   = 3'd5
    } tx_state_t;

    typedef enum logic {
        RX_HUNT = 1'b0,
        RX_DATA = 1'b1
    } rx_state_t;

    tx_state_t  tx_state_q, tx_state_d;
    rx_state_t  rx_state_q, rx_state_d;

    logic       mode_q, mode_d;
    logic [3:0] cnt_q, cnt_d;
    logic [6:0] tx_cnt_q, tx_cnt_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic       hold_last_q, hold_last_d;
    logic       hold_valid_q, hold_valid_d;
    logic [7:0] shift_q, shift_d;
    logic       cur_last_q, cur_last_d;
    logic [1:0] dib_q, dib_d;
    logic       crsdv_q, crsdv_d;
    logic [1:0] rxd_q, rxd_d;
    logic       rxer_q, rxer_d;
    logic       uf_q, uf_d;
    logic       txen_q, txen_d;
    logic [1:0] txd_q, txd_d;
    logic [1:0] prev_q, prev_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic [1:0] rx_cnt_q, rx_cnt_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_end_q, rx_end_d;
    logic       rx_err_q, rx_err_d;

    logic       clear;
    logic       action;
    logic       load_byte;

    // A speed change behaves exactly like reset so no half-rate frame survives.
    assign clear  = rst | (mode_q != mode_speed);
    assign action = (cnt_q == 4'd0);
    assign mode_d = mode_speed;

    // FSM state registers for both paths.
    always_ff @(posedge rmii_ref_clk) begin
        if (clear) begin
            tx_state_q <= TX_IDLE;
            rx_state_q <= RX_HUNT;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
        end
    end

    // Datapath and output registers; mode_q always tracks the pin.
    always_ff @(posedge rmii_ref_clk) begin
        mode_q <= mode_d;
        if (clear) begin
            cnt_q        <= 4'd0;
            tx_cnt_q     <= 7'd0;
            hold_data_q  <= 8'd0;
            hold_last_q  <= 1'b0;
            hold_valid_q <= 1'b0;
            shift_q      <= 8'd0;
            cur_last_q   <= 1'b0;
            dib_q        <= 2'd0;
            crsdv_q      <= 1'b0;
            rxd_q        <= 2'd0;
            rxer_q       <= 1'b0;
            uf_q         <= 1'b0;
            txen_q       <= 1'b0;
            txd_q        <= 2'd0;
            prev_q       <= 2'd0;
            rx_byte_q    <= 8'd0;
            rx_cnt_q     <= 2'd0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= 8'd0;
            rx_end_q     <= 1'b0;
            rx_err_q     <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            tx_cnt_q     <= tx_cnt_d;
            hold_data_q  <= hold_data_d;
            hold_last_q  <= hold_last_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            cur_last_q   <= cur_last_d;
            dib_q        <= dib_d;
            crsdv_q      <= crsdv_d;
            rxd_q        <= rxd_d;
            rxer_q       <= rxer_d;
            uf_q         <= uf_d;
            txen_q       <= txen_d;
            txd_q        <= txd_d;
            prev_q       <= prev_d;
            rx_byte_q    <= rx_byte_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_valid_q   <= rx_valid_d;
            rx_data_q    <= rx_data_d;
            rx_end_q     <= rx_end_d;
            rx_err_q     <= rx_err_d;
        end
    end

    // Action-strobe divider: 0..9 in 10M, pinned at 0 in 100M.
    always_comb begin
        if (mode_q) begin
            cnt_d = 4'd0;
        end else if (cnt_q == 4'd9) begin
            cnt_d = 4'd0;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // TX next-state logic.
    always_comb begin
        tx_state_d = tx_state_q;
        if (action) begin
            case (tx_state_q)
                TX_IDLE:  tx_state_d = hold_valid_q ? TX_PRE : TX_IDLE;
                TX_PRE:   tx_state_d = (tx_cnt_q == PRE_PERIODS) ? TX_SFD : TX_PRE;
                TX_SFD:   tx_state_d = TX_DATA;
                TX_DATA: begin
                    // dib_q wraps to 0 once all four dibits of a byte have gone out.
                    if (dib_q != 2'd0) begin
                        tx_state_d = TX_DATA;
                    end else if (cur_last_q) begin
                        tx_state_d = TX_IFG;
                    end else if (hold_valid_q) begin
                        tx_state_d = TX_DATA;
                    end else begin
                        tx_state_d = TX_UNDER;
                    end
                end
                TX_UNDER: tx_state_d = TX_IFG;
                TX_IFG:   tx_state_d = (tx_cnt_q == IFG_PERIODS) ? TX_IDLE : TX_IFG;
                default:  tx_state_d = TX_IDLE;
            endcase
        end else begin
            tx_state_d = tx_state_q;
        end
    end

    // TX outputs and datapath: the dibit for the coming period is registered on the action edge.
    always_comb begin
        hold_data_d  = hold_data_q;
        hold_last_d  = hold_last_q;
        hold_valid_d = hold_valid_q;
        shift_d      = shift_q;
        cur_last_d   = cur_last_q;
        dib_d        = dib_q;
        tx_cnt_d     = tx_cnt_q;
        crsdv_d      = crsdv_q;
        rxd_d        = rxd_q;
        rxer_d       = rxer_q;
        uf_d         = 1'b0;
        load_byte    = 1'b0;
        // Fill only when empty, so a drain and a fill never coincide.
        if (tx_valid && !hold_valid_q) begin
            hold_data_d  = tx_data;
            hold_last_d  = tx_last;
            hold_valid_d = 1'b1;
        end else begin
            hold_valid_d = hold_valid_q;
        end
        if (action) begin
            load_byte = (tx_state_d == TX_DATA) &&
                        ((tx_state_q == TX_SFD) || (dib_q == 2'd0));
            if (tx_state_d != tx_state_q) begin
                tx_cnt_d = 7'd1;
            end else begin
                tx_cnt_d = tx_cnt_q + 7'd1;
            end
            case (tx_state_d)
                TX_PRE: begin
                    crsdv_d = 1'b1;
                    rxd_d   = 2'b01;
                    rxer_d  = 1'b0;
                end
                TX_SFD: begin
                    crsdv_d = 1'b1;
                    rxd_d   = 2'b11;
                    rxer_d  = 1'b0;
                end
                TX_DATA: begin
                    crsdv_d = 1'b1;
                    rxer_d  = 1'b0;
                    if (load_byte) begin
                        rxd_d        = hold_data_q[1:0];
                        shift_d      = {2'b00, hold_data_q[7:2]};
                        cur_last_d   = hold_last_q;
                        hold_valid_d = 1'b0;
                        dib_d        = 2'd1;
                    end else begin
                        rxd_d   = shift_q[1:0];
                        shift_d = {2'b00, shift_q[7:2]};
                        dib_d   = dib_q + 2'd1;
                    end
                end
                TX_UNDER: begin
                    crsdv_d = 1'b1;
                    rxd_d   = 2'b00;
                    rxer_d  = 1'b1;
                    uf_d    = 1'b1;
                end
                default: begin
                    crsdv_d = 1'b0;
                    rxd_d   = 2'b00;
                    rxer_d  = 1'b0;
                end
            endcase
        end else begin
            load_byte = 1'b0;
        end
    end

    // RX next-state logic.
    always_comb begin
        rx_state_d = rx_state_q;
        if (action) begin
            case (rx_state_q)
                RX_HUNT: begin
                    if (txen_q && (prev_q == 2'b01) && (txd_q == 2'b11)) begin
                        rx_state_d = RX_DATA;
                    end else begin
                        rx_state_d = RX_HUNT;
                    end
                end
                RX_DATA: rx_state_d = txen_q ? RX_DATA : RX_HUNT;
                default: rx_state_d = RX_HUNT;
            endcase
        end else begin
            rx_state_d = rx_state_q;
        end
    end

    // RX datapath: input capture every cycle, byte assembly and pulses on action.
    always_comb begin
        txen_d     = mac_rmii_txen;
        txd_d      = mac_rmii_txd;
        prev_d     = prev_q;
        rx_byte_d  = rx_byte_q;
        rx_cnt_d   = rx_cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_end_d   = 1'b0;
        rx_err_d   = 1'b0;
        if (action) begin
            case (rx_state_q)
                RX_HUNT: begin
                    // Forget history across idle so a stale 01 cannot pair with a later 11.
                    prev_d   = txen_q ? txd_q : 2'b00;
                    rx_cnt_d = 2'd0;
                end
                RX_DATA: begin
                    if (txen_q) begin
                        rx_byte_d = {txd_q, rx_byte_q[7:2]};
                        rx_cnt_d  = rx_cnt_q + 2'd1;
                        if (rx_cnt_q == 2'd3) begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = {txd_q, rx_byte_q[7:2]};
                        end else begin
                            rx_valid_d = 1'b0;
                        end
                    end else begin
                        rx_end_d = 1'b1;
                        rx_err_d = (rx_cnt_q != 2'd0);
                        prev_d   = 2'b00;
                        rx_cnt_d = 2'd0;
                    end
                end
                default: begin
                    prev_d   = 2'b00;
                    rx_cnt_d = 2'd0;
                end
            endcase
        end else begin
            prev_d = prev_q;
        end
    end

    assign tx_ready       = ~hold_valid_q;
    assign mac_rmii_crsdv = crsdv_q;
    assign mac_rmii_rxd   = rxd_q;
    assign mac_rmii_rxer  = rxer_q;
    assign tx_underflow   = uf_q;
    assign rx_valid       = rx_valid_q;
    assign rx_data        = rx_data_q;
    assign rx_end         = rx_end_q;
    assign rx_err         = rx_err_q;

endmodule

// File: tb/tb_rmii_phy_emu.sv
// -----------------------------------------------------------------------------
// tb_rmii_phy_emu
// Directed self-checking bench for rmii_phy_emu with default parameters.
// A loopback switch can route CRS_DV/RXD back into TX_EN/TXD.
// -----------------------------------------------------------------------------
module tb_rmii_phy_emu;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_speed;
    logic       loop_en;
    logic       drv_txen;
    logic [1:0] drv_txd;
    logic       mac_txen;
    logic [1:0] mac_txd;
    logic       crsdv;
    logic       rxer;
    logic [1:0] rxd;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_underflow;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_end;
    logic       rx_err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] tx_bytes [64];
    logic [1:0] t1_data_dib [4];
    logic [1:0] t4_dib [6];

    // Monitor state (written only by the monitor process)
    logic [7:0] rxq [$];
    int         end_cnt;
    int         last_err;
    int         uf_cnt;
    int         hi_cnt;
    int         er_cnt;
    int         cyc;
    int         last_chg;
    int         align_bad;
    bit         seen;
    bit         mon_clr = 1'b0;
    logic [3:0] prev_out;

    always #10 clk = ~clk;

    assign mac_txen = loop_en ? crsdv : drv_txen;
    assign mac_txd  = loop_en ? rxd   : drv_txd;

    rmii_phy_emu dut (
        .rmii_ref_clk   (clk),
        .rst            (rst),
        .mode_speed     (mode_speed),
        .mac_rmii_txen  (mac_txen),
        .mac_rmii_txd   (mac_txd),
        .mac_rmii_crsdv (crsdv),
        .mac_rmii_rxer  (rxer),
        .mac_rmii_rxd   (rxd),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_data        (tx_data),
        .tx_last        (tx_last),
        .tx_underflow   (tx_underflow),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_end         (rx_end),
        .rx_err         (rx_err)
    );

    // Output monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_clr) begin
            rxq.delete();
            end_cnt   = 0;
            last_err  = 0;
            uf_cnt    = 0;
            hi_cnt    = 0;
            er_cnt    = 0;
            cyc       = 0;
            last_chg  = 0;
            align_bad = 0;
            seen      = 1'b0;
            prev_out  = {crsdv, rxd, rxer};
        end else begin
            cyc = cyc + 1;
            if (rx_valid) rxq.push_back(rx_data);
            if (rx_end) begin
                end_cnt  = end_cnt + 1;
                last_err = int'(rx_err);
            end
            if (tx_underflow) uf_cnt = uf_cnt + 1;
            if (crsdv) hi_cnt = hi_cnt + 1;
            if (rxer) er_cnt = er_cnt + 1;
            if ({crsdv, rxd, rxer} != prev_out) begin
                if (seen && (((cyc - last_chg) % 10) != 0)) align_bad = align_bad + 1;
                last_chg = cyc;
                seen     = 1'b1;
            end
            prev_out = {crsdv, rxd, rxer};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic push_bytes(input int n, input bit with_last);
        int guard;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            guard = 0;
            while (!tx_ready && guard < 5000) begin
                @(negedge clk);
                guard = guard + 1;
            end
            chk("push_timeout", (guard >= 5000) ? 32'd1 : 32'd0, 32'd0);
            if (guard >= 5000) return;
            tx_valid = 1'b1;
            tx_data  = tx_bytes[i];
            tx_last  = with_last && (i == n - 1);
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
            tx_last  = 1'b0;
        end
    endtask

    task automatic wait_end(input int budget);
        int k;
        k = 0;
        while (end_cnt < 1 && k < budget) begin
            @(negedge clk);
            k = k + 1;
        end
        chk("wait_rx_end", (end_cnt >= 1) ? 32'd1 : 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_crsdv_high(input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while (!crsdv && k < budget) begin
            @(negedge clk);
            k = k + 1;
        end
        chk("wait_crsdv", 32'(crsdv), 32'd1);
    endtask

    task automatic rx_dibit(input logic en, input logic [1:0] d);
        @(negedge clk);
        drv_txen = en;
        drv_txd  = d;
    endtask

    task automatic rx_preamble();
        for (int i = 0; i < 32; i++) rx_dibit(1'b1, (i == 31) ? 2'b11 : 2'b01);
    endtask

    task automatic chk_rx(input string tag, input int n);
        chk({tag, "_count"}, 32'(rxq.size()), 32'(n));
        for (int i = 0; i < n; i++)
            chk({tag, "_byte"}, (i < rxq.size()) ? 32'(rxq[i]) : 32'h100, 32'(tx_bytes[i]));
        chk({tag, "_end"}, 32'(end_cnt), 32'd1);
        chk({tag, "_err"}, 32'(last_err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        mode_speed = 1'b1;
        loop_en    = 1'b0;
        drv_txen   = 1'b0;
        drv_txd    = 2'b00;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        tx_last    = 1'b0;
        t1_data_dib = '{2'b01, 2'b01, 2'b10, 2'b10};
        t4_dib      = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_crsdv", 32'(crsdv), 32'd0);
        chk("rst_rxd", 32'(rxd), 32'd0);
        chk("rst_rxer", 32'(rxer), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_end", 32'(rx_end), 32'd0);
        chk("rst_underflow", 32'(tx_underflow), 32'd0);

        // Single byte 0xA5 at 100M: 31x01, 11, 01,01,10,10 then >=48 low
        clear_mon();
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tx_last  = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        @(negedge clk);
        chk("t1_pre_launch", 32'(crsdv), 32'd0);
        for (int j = 0; j < 36; j++) begin
            @(negedge clk);
            chk("t1_crsdv", 32'(crsdv), 32'd1);
            if (j < 31)       chk("t1_pre_dibit", 32'(rxd), 32'd1);
            else if (j == 31) chk("t1_sfd_dibit", 32'(rxd), 32'd3);
            else              chk("t1_data_dibit", 32'(rxd), 32'(t1_data_dib[j - 32]));
        end
        for (int j = 0; j < 48; j++) begin
            @(negedge clk);
            chk("t1_ifg_low", 32'(crsdv), 32'd0);
        end
        chk("t1_underflow", 32'(uf_cnt), 32'd0);

        // Loopback 100M, 64 random bytes
        loop_en = 1'b1;
        for (int i = 0; i < 64; i++) tx_bytes[i] = 8'($urandom_range(0, 255));
        clear_mon();
        push_bytes(64, 1'b1);
        wait_end(1000);
        chk_rx("t2_loop100", 64);
        chk("t2_underflow", 32'(uf_cnt), 32'd0);

        // Underflow after 3 bytes without tx_last
        loop_en = 1'b0;
        repeat (60) @(negedge clk);
        tx_bytes[0] = 8'h11;
        tx_bytes[1] = 8'h22;
        tx_bytes[2] = 8'h33;
        clear_mon();
        push_bytes(3, 1'b0);
        begin
            int k;
            k = 0;
            while (!tx_underflow && k < 300) begin
                @(negedge clk);
                k = k + 1;
            end
        end
        chk("t3_uf_pulse", 32'(tx_underflow), 32'd1);
        chk("t3_uf_crsdv", 32'(crsdv), 32'd1);
        chk("t3_uf_rxer", 32'(rxer), 32'd1);
        chk("t3_uf_rxd", 32'(rxd), 32'd0);
        for (int j = 0; j < 48; j++) begin
            @(negedge clk);
            chk("t3_ifg_low", 32'(crsdv), 32'd0);
        end
        chk("t3_uf_count", 32'(uf_cnt), 32'd1);
        chk("t3_high_periods", 32'(hi_cnt), 32'd45);
        chk("t3_rxer_periods", 32'(er_cnt), 32'd1);

        // RX: preamble+SFD, 6 dibits, txen low -> one byte 0x4E, rx_end with error
        clear_mon();
        rx_preamble();
        for (int i = 0; i < 6; i++) begin
            rx_dibit(1'b1, t4_dib[i]);
            if (i == 5) begin
                chk("t4_rx_valid_lat", 32'(rx_valid), 32'd1);
                chk("t4_rx_data", 32'(rx_data), 32'h4E);
            end
        end
        rx_dibit(1'b0, 2'b00);
        repeat (5) @(negedge clk);
        chk("t4_count", 32'(rxq.size()), 32'd1);
        chk("t4_byte", (rxq.size() > 0) ? 32'(rxq[0]) : 32'h100, 32'h4E);
        chk("t4_end", 32'(end_cnt), 32'd1);
        chk("t4_err", 32'(last_err), 32'd1);

        // 10M loopback 0x00, 0xFF, 0x5D
        @(negedge clk);
        mode_speed = 1'b0;
        repeat (3) @(negedge clk);
        loop_en = 1'b1;
        tx_bytes[0] = 8'h00;
        tx_bytes[1] = 8'hFF;
        tx_bytes[2] = 8'h5D;
        clear_mon();
        push_bytes(3, 1'b1);
        wait_end(2000);
        chk_rx("t5_loop10", 3);
        chk("t5_high_cycles", 32'(hi_cnt), 32'd440);
        chk("t5_dibit_align", 32'(align_bad), 32'd0);

        // Speed toggle in the middle of a 10M data byte
        repeat (520) @(negedge clk);
        tx_bytes[0] = 8'h96;
        clear_mon();
        push_bytes(1, 1'b1);
        wait_crsdv_high(100);
        repeat (340) @(negedge clk);
        chk("t5_mid_data", 32'(crsdv), 32'd1);
        mode_speed = 1'b1;
        @(negedge clk);
        chk("t5_toggle_crsdv", 32'(crsdv), 32'd0);
        chk("t5_toggle_ready", 32'(tx_ready), 32'd1);
        repeat (60) @(negedge clk);
        chk("t5_toggle_no_end", 32'(end_cnt), 32'd0);
        chk("t5_toggle_no_byte", 32'(rxq.size()), 32'd0);
        chk("t5_toggle_no_uf", 32'(uf_cnt), 32'd0);
        tx_bytes[0] = 8'h3C;
        tx_bytes[1] = 8'hC3;
        clear_mon();
        push_bytes(2, 1'b1);
        wait_end(500);
        chk_rx("t5_after_toggle", 2);

        // Reset mid-preamble
        loop_en = 1'b0;
        repeat (60) @(negedge clk);
        tx_bytes[0] = 8'h81;
        clear_mon();
        push_bytes(1, 1'b1);
        wait_crsdv_high(50);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_crsdv", 32'(crsdv), 32'd0);
        chk("t6_rst_rxd", 32'(rxd), 32'd0);
        chk("t6_rst_rxer", 32'(rxer), 32'd0);
        chk("t6_rst_ready", 32'(tx_ready), 32'd1);
        repeat (40) @(negedge clk);
        chk("t6_stays_idle", 32'(hi_cnt), 32'd6);

        // Reset mid-receive
        clear_mon();
        rx_preamble();
        rx_dibit(1'b1, 2'b10);
        rx_dibit(1'b1, 2'b01);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("t6_rst_rx_end", 32'(rx_end), 32'd0);
        rx_dibit(1'b1, 2'b01);
        rx_dibit(1'b0, 2'b00);
        repeat (10) @(negedge clk);
        chk("t6_no_end", 32'(end_cnt), 32'd0);
        chk("t6_no_byte", 32'(rxq.size()), 32'd0);

        // Clean frame after the resets
        loop_en = 1'b1;
        tx_bytes[0] = 8'h5A;
        tx_bytes[1] = 8'hE7;
        clear_mon();
        push_bytes(2, 1'b1);
        wait_end(500);
        chk_rx("t6_after_rst", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
